i2s_sequencer: RTL and testbench
================================

# i2s_sequencer

Timing master for the I2S receive/transmit datapath. Divides the system clock `ck` to produce the bit clock `sck` and word select `ws`, and produces the `sample` and `tx_en` strobes and the 6-bit `frame_posn` slot counter consumed by `i2s_rx` and the transmit shifter. Provides a clean start/stop sequence so frames are never truncated. Sits between the audio-path control registers and every I2S rx/tx instance sharing one bus.

## Interface

Parameters:
- `DIVIDER`, 12: `ck` cycles per `sck` period. Even, ≥4.
- `CLOCKS`, 64: `sck` periods per frame. Legal values are 32 or 64.

Ports:
- `ck`, in, 1: system clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `en`, in, 1: run request, level-sensitive.
- `sck`, out, 1: I2S bit clock.
- `ws`, out, 1: word select. 0 = left, 1 = right.
- `sample`, out, 1: one-`ck` strobe at the `sck` rising edge; this is the rx sample point.
- `tx_en`, out, 1: one-`ck` strobe at the `sck` falling edge; this is the tx shift point.
- `frame_posn`, out, 6: slot index 0..CLOCKS-1. Bit 5 is always 0 when CLOCKS=32.
- `frame_start`, out, 1: one-`ck` strobe in the first `ck` of slot 0.
- `frame_done`, out, 1: one-`ck` strobe in the last `ck` of slot CLOCKS-1.
- `busy`, out, 1: high in every state except IDLE.

## Operation

- Internal `prescale` counts 0..DIVIDER-1 and wraps. `frame_posn` increments on each wrap, modulo CLOCKS.
- States:
  - IDLE: counters held at 0; `sck`=0, `ws`=0; no strobes.
  - RUN: counters free-run.
  - STOP: counters free-run until the frame ends.
- Transitions:
  - IDLE→RUN when `en`=1. The first RUN cycle has `prescale`=0 and `frame_posn`=0, and asserts `frame_start`.
  - RUN→STOP when `en`=0.
  - STOP→RUN when `en`=1 again. There is no discontinuity in the counters.
  - STOP→IDLE on the cycle after the `frame_done` strobe. Counters return to 0.
  - RUN stays in RUN across frame boundaries.
- Decodes, valid only in RUN or STOP:
  - `sck` = (`prescale` ≥ DIVIDER/2).
  - `sample` = (`prescale` == DIVIDER/2).
  - `tx_en` = (`prescale` == 0).
  - `ws` = (`frame_posn` ≥ CLOCKS/2).
  - `frame_start` = (`prescale`==0 && `frame_posn`==0).
  - `frame_done` = (`prescale`==DIVIDER-1 && `frame_posn`==CLOCKS-1).
- Channel alignment follows standard I2S:
  - Left MSB occupies slot 1; right MSB occupies slot CLOCKS/2+1.
  - `ws` changes one slot before each MSB, in slot 0 and slot CLOCKS/2.
- `sck` and `ws` come directly from flops so the pins are glitch-free. The strobes may be decoded from the registered counters.

## Timing

- Reset values: state IDLE, `prescale`=0, `frame_posn`=0. All outputs are 0, including `busy`.
- Latency from `en` rising, sampled at edge N: `busy`, `tx_en` and `frame_start` are high in the cycle after edge N. `sample` first fires DIVIDER/2 cycles later.
- `en` pulse shorter than one `ck` cycle and not sampled high on any edge: ignored.
- `en` high for one cycle only: exactly one full frame is produced, then IDLE. `frame_done` fires once.
- `en` falling and rising again inside the same frame: the frame continues uninterrupted and no extra `frame_start` is generated.
- `en`=0 on the same edge as `frame_done` in RUN: go to STOP. The next frame then runs to completion.
- `rst` asserted mid-frame: outputs drop to 0 immediately (asynchronous). After release, the block stays in IDLE until `en` is sampled high.
- `frame_posn` wraps CLOCKS-1→0 on the same edge that asserts `frame_start`.
- Frame length is DIVIDER×CLOCKS `ck` cycles: 768 with the defaults.

## Structure

- Package `i2s_pkg`:
  - state enum `{IDLE, RUN, STOP}`;
  - `FRAME_W`=6;
  - legal-CLOCKS check constants.
- One sub-module, `i2s_prescaler`:
  - generic mod-N counter with enable, synchronous clear and a wrap strobe;
  - instantiated twice: for `prescale` (N=DIVIDER) and for `frame_posn` (N=CLOCKS, enabled by the prescale wrap).
- Elaboration-time error when DIVIDER is odd or <4, or when CLOCKS ∉ {32, 64}.

## Test plan

- Reset, then `en`=0 for 100 cycles → all outputs stay 0 and `busy`=0.
- DIVIDER=12, CLOCKS=64, `en` held high:
  - `sck` period is 12 cycles with a 6/6 duty cycle;
  - `sample` is at prescale 6 and `tx_en` at prescale 0;
  - `ws` rises when `frame_posn`=32 and falls at 0;
  - `frame_start` recurs every 768 cycles.
- Loopback into `i2s_rx` (BITS=24) plus a tx shifter driven by `tx_en`, sending L=0xf0f0f0, R=0xcafedb → `left`/`right` read back identical at slot 0 of the next frame.
- CLOCKS=32, BITS=16, sending L=0xface, R=0x1234 → `left` is valid by slot 18 and `right` by slot 2 of the next frame. `frame_posn[5]` stays 0.
- `en` dropped at `frame_posn`=10 → `busy` stays high until `frame_done` at slot 63, then IDLE. `frame_posn` returns to 0.
- `rst` pulsed at `frame_posn`=40 → outputs are 0 on the same edge. Re-enabling restarts with `frame_start` at slot 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S timing master and its helpers.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  localparam int FRAME_W      = 6;
  localparam int CLOCKS_SHORT = 32;
  localparam int CLOCKS_LONG  = 64;

  function automatic bit legal_clocks(input int clocks);
    return (clocks == CLOCKS_SHORT) || (clocks == CLOCKS_LONG);
  endfunction

endpackage

// File: rtl/i2s_prescaler.sv
// Generic mod-N counter with enable, synchronous clear and a wrap strobe.
module i2s_prescaler #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_sequencer.sv
// I2S timing master: bit clock, word select, sample/shift strobes and slot counter
// with a start/stop sequence that never truncates a frame.
module i2s_sequencer
  import i2s_pkg::*;
#(
  parameter int DIVIDER = 12,
  parameter int CLOCKS  = 64
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               en,
  output logic               sck,
  output logic               ws,
  output logic               sample,
  output logic               tx_en,
  output logic [FRAME_W-1:0] frame_posn,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy
);

  localparam int PS_W = $clog2(DIVIDER);

  localparam logic [PS_W-1:0]    PS_HALF     = PS_W'(DIVIDER / 2);
  localparam logic [PS_W-1:0]    PS_PRE_HALF = PS_W'(DIVIDER / 2 - 1);
  localparam logic [PS_W-1:0]    PS_LAST     = PS_W'(DIVIDER - 1);
  localparam logic [FRAME_W-1:0] FP_PRE_HALF = FRAME_W'(CLOCKS / 2 - 1);
  localparam logic [FRAME_W-1:0] FP_LAST     = FRAME_W'(CLOCKS - 1);

  if ((DIVIDER % 2) != 0 || DIVIDER < 4) begin : g_bad_divider
    $error("i2s_sequencer: DIVIDER must be even and at least 4");
  end
  if (!legal_clocks(CLOCKS)) begin : g_bad_clocks
    $error("i2s_sequencer: CLOCKS must be 32 or 64");
  end

  state_t            state;
  state_t            state_next;
  logic              running;
  logic [PS_W-1:0]   prescale;
  logic              ps_wrap;
  logic              fp_wrap;

  assign running = (state != IDLE);

  i2s_prescaler #(.N(DIVIDER), .W(PS_W)) u_prescale (
    .ck    (ck),
    .rst   (rst),
    .en    (running),
    .clr   (!running),
    .count (prescale),
    .wrap  (ps_wrap)
  );

  // Slot counter only steps on a prescale wrap, so its wrap is the last ck of the frame.
  i2s_prescaler #(.N(CLOCKS), .W(FRAME_W)) u_frame (
    .ck    (ck),
    .rst   (rst),
    .en    (ps_wrap),
    .clr   (!running),
    .count (frame_posn),
    .wrap  (fp_wrap)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN:  if (!en) state_next = STOP;
      STOP: begin
        if (en) begin
          state_next = RUN;
        end else if (fp_wrap) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pins are registered one cycle ahead of the counter value they decode.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sck <= 1'b0;
      ws  <= 1'b0;
    end else if (state_next == IDLE) begin
      sck <= 1'b0;
      ws  <= 1'b0;
    end else if (running) begin
      if (prescale == PS_PRE_HALF) begin
        sck <= 1'b1;
      end else if (prescale == PS_LAST) begin
        sck <= 1'b0;
      end
      if (ps_wrap && frame_posn == FP_PRE_HALF) begin
        ws <= 1'b1;
      end else if (ps_wrap && frame_posn == FP_LAST) begin
        ws <= 1'b0;
      end
    end
  end

  assign busy        = running;
  assign sample      = running && (prescale == PS_HALF);
  assign tx_en       = running && (prescale == '0);
  assign frame_start = running && (prescale == '0) && (frame_posn == '0);
  assign frame_done  = fp_wrap;

endmodule

// File: tb/tb_i2s_sequencer.sv
// Directed bench for i2s_sequencer: per-cycle comparison against hand-derived
// prescale/slot arithmetic across start, stop, restart, glitch and reset cases.
module tb_i2s_sequencer;

  logic       ck = 1'b0;
  logic       rst;
  logic       en;
  logic       en2;

  logic       sck, ws, sample, tx_en, frame_start, frame_done, busy;
  logic [5:0] frame_posn;
  logic       sck2, ws2, sample2, tx_en2, frame_start2, frame_done2, busy2;
  logic [5:0] frame_posn2;

  logic [12:0] vec;
  logic [12:0] vec2;

  int n_checks = 0;
  int n_pass   = 0;
  int bad_cnt;
  int done_cnt;

  always #5 ck = ~ck;

  i2s_sequencer #(.DIVIDER(12), .CLOCKS(64)) dut (
    .ck          (ck),
    .rst         (rst),
    .en          (en),
    .sck         (sck),
    .ws          (ws),
    .sample      (sample),
    .tx_en       (tx_en),
    .frame_posn  (frame_posn),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  i2s_sequencer #(.DIVIDER(4), .CLOCKS(32)) dut2 (
    .ck          (ck),
    .rst         (rst),
    .en          (en2),
    .sck         (sck2),
    .ws          (ws2),
    .sample      (sample2),
    .tx_en       (tx_en2),
    .frame_posn  (frame_posn2),
    .frame_start (frame_start2),
    .frame_done  (frame_done2),
    .busy        (busy2)
  );

  assign vec  = {sck, ws, sample, tx_en, frame_start, frame_done, busy, frame_posn};
  assign vec2 = {sck2, ws2, sample2, tx_en2, frame_start2, frame_done2, busy2, frame_posn2};

  // Expected output vector k cycles after the first running cycle.
  function automatic logic [12:0] exp_vec(input int k, input int d, input int c, input bit run);
    int         ps;
    int         fp;
    logic [5:0] f6;
    if (!run) return '0;
    ps = k % d;
    fp = (k / d) % c;
    f6 = 6'(fp);
    return {(ps >= d / 2), (fp >= c / 2), (ps == d / 2), (ps == 0),
            (ps == 0 && fp == 0), (ps == d - 1 && fp == c - 1), 1'b1, f6};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive en for the next edge, then move to the following negedge.
  task automatic applyStimulus(input logic v);
    en = v;
    @(negedge ck);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    en2 = 1'b0;
    repeat (3) @(negedge ck);
    rst = 1'b0;
    checkOutput("reset_state", 32'(vec), 32'h0);
    checkOutput("reset_state_c32", 32'(vec2), 32'h0);

    bad_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0);
      if (vec !== '0) bad_cnt++;
    end
    checkOutput("idle_quiet", 32'(bad_cnt), 32'h0);

    // Two full frames held on, then a short en gap at slot 5 and a stop at slot 10.
    applyStimulus(1'b1);
    for (int k = 0; k < 3 * 768; k++) begin
      checkOutput($sformatf("run k=%0d", k), 32'(vec), 32'(exp_vec(k, 12, 64, 1'b1)));
      applyStimulus(!((k >= 1536 + 60 && k < 1536 + 63) || k >= 1536 + 120));
    end
    checkOutput("stop_to_idle", 32'(vec), 32'h0);
    applyStimulus(1'b0);
    checkOutput("stop_stays_idle", 32'(vec), 32'h0);

    // Single-cycle en: exactly one frame.
    applyStimulus(1'b1);
    done_cnt = 0;
    for (int k = 0; k < 768; k++) begin
      checkOutput($sformatf("oneshot k=%0d", k), 32'(vec), 32'(exp_vec(k, 12, 64, 1'b1)));
      done_cnt += int'(frame_done);
      applyStimulus(1'b0);
    end
    checkOutput("oneshot_idle", 32'(vec), 32'h0);
    checkOutput("oneshot_done_count", 32'(done_cnt), 32'd1);

    // en dropped on the frame_done edge: the next frame still completes.
    applyStimulus(1'b1);
    for (int k = 0; k < 1536; k++) begin
      checkOutput($sformatf("edgestop k=%0d", k), 32'(vec), 32'(exp_vec(k, 12, 64, 1'b1)));
      applyStimulus(k < 767);
    end
    checkOutput("edgestop_idle", 32'(vec), 32'h0);

    // Sub-cycle en pulse between edges.
    #1 en = 1'b1;
    #2 en = 1'b0;
    @(negedge ck);
    checkOutput("glitch_ignored", 32'(vec), 32'h0);
    applyStimulus(1'b0);
    checkOutput("glitch_ignored2", 32'(vec), 32'h0);

    // Asynchronous reset at slot 40.
    applyStimulus(1'b1);
    for (int k = 0; k < 480; k++) begin
      checkOutput($sformatf("prerst k=%0d", k), 32'(vec), 32'(exp_vec(k, 12, 64, 1'b1)));
      applyStimulus(1'b1);
    end
    checkOutput("at_slot40", 32'(vec), 32'(exp_vec(480, 12, 64, 1'b1)));
    #1 rst = 1'b1;
    #1 checkOutput("rst_async", 32'(vec), 32'h0);
    en = 1'b0;
    @(negedge ck);
    rst = 1'b0;
    bad_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      if (vec !== '0) bad_cnt++;
    end
    checkOutput("post_rst_idle", 32'(bad_cnt), 32'h0);
    applyStimulus(1'b1);
    for (int k = 0; k < 40; k++) begin
      checkOutput($sformatf("restart k=%0d", k), 32'(vec), 32'(exp_vec(k, 12, 64, 1'b1)));
      applyStimulus(1'b0);
    end

    // 32-slot frame with a 4-cycle bit clock.
    en2 = 1'b1;
    @(negedge ck);
    bad_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      checkOutput($sformatf("c32 k=%0d", k), 32'(vec2), 32'(exp_vec(k, 4, 32, 1'b1)));
      if (frame_posn2[5] !== 1'b0) bad_cnt++;
      @(negedge ck);
    end
    checkOutput("c32_posn_bit5", 32'(bad_cnt), 32'h0);
    en2 = 1'b0;
    repeat (130) @(negedge ck);
    checkOutput("c32_idle", 32'(vec2), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
